// File: rtl/qs_snk.sv
// Sink for the sorter's output stream: frames packets, checks unsigned non-decreasing
// order, reports per-packet status and keeps saturating packet/error counters.
module qs_snk #(
    parameter int W     = 32,
    parameter int N     = 16,
    parameter int CNT_W = 16,
    localparam int LEN_W = $clog2(N + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic             in_err,
    input  logic [W-1:0]     in_dat,
    input  logic             clr,
    output logic             stat_vld_r,
    output logic             stat_ok_r,
    output logic [3:0]       stat_err_r,
    output logic [LEN_W-1:0] stat_len_r,
    output logic             busy_r,
    output logic [CNT_W-1:0] pkt_cnt_r,
    output logic [CNT_W-1:0] err_cnt_r
);

    typedef enum logic {IDLE, PKT} state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(N + 1);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [3:0]       E_FRAME = 4'b0010;

    state_t             state, state_nx;
    logic [W-1:0]       last;
    logic [LEN_W-1:0]   len, len_inc;
    logic [3:0]         err, beat_err;
    logic               len_over;

    logic               cls, cls2;
    logic [3:0]         cls_err;
    logic [LEN_W-1:0]   cls_len;

    // A sop&eop beat arriving inside PKT closes two packets at once; the second
    // (single-beat) packet is parked here and reported one cycle later.
    logic               pend, pend_nx;
    logic [3:0]         pend_err, pend_err_nx;
    logic [LEN_W-1:0]   pend_len, pend_len_nx;

    logic               emit;
    logic [3:0]         emit_err;
    logic [LEN_W-1:0]   emit_len;

    always_comb begin
        len_inc  = (len >= LEN_MAX) ? LEN_MAX : len + 1'b1;
        len_over = (len >= LEN_W'(N));
        beat_err = {err[3] | in_err, err[2] | len_over, err[1], err[0] | (in_dat < last)};

        state_nx = state;
        cls      = 1'b0;
        cls2     = 1'b0;
        cls_err  = '0;
        cls_len  = '0;

        if (in_vld) begin
            if (in_sop)
                state_nx = in_eop ? IDLE : PKT;
            else if (state == PKT && in_eop)
                state_nx = IDLE;

            if (state == PKT) begin
                if (in_sop) begin
                    cls     = 1'b1;
                    cls_err = err | E_FRAME;
                    cls_len = len;
                    cls2    = in_eop;
                end else if (in_eop) begin
                    cls     = 1'b1;
                    cls_err = beat_err;
                    cls_len = len_inc;
                end
            end else begin
                if (in_sop && in_eop) begin
                    cls     = 1'b1;
                    cls_err = {in_err, 3'b000};
                    cls_len = LEN_ONE;
                end else if (!in_sop) begin
                    cls     = 1'b1;
                    cls_err = E_FRAME;
                    cls_len = '0;
                end
            end
        end

        emit        = pend | cls;
        emit_err    = pend ? pend_err : cls_err;
        emit_len    = pend ? pend_len : cls_len;
        pend_nx     = pend ? cls : cls2;
        pend_err_nx = pend ? cls_err : {in_err, 3'b000};
        pend_len_nx = pend ? cls_len : LEN_ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last       <= '0;
            len        <= '0;
            err        <= '0;
            pend       <= 1'b0;
            pend_err   <= '0;
            pend_len   <= '0;
            stat_vld_r <= 1'b0;
            stat_ok_r  <= 1'b0;
            stat_err_r <= '0;
            stat_len_r <= '0;
            busy_r     <= 1'b0;
            pkt_cnt_r  <= '0;
            err_cnt_r  <= '0;
        end else begin
            state      <= state_nx;
            busy_r     <= (state_nx == PKT);
            pend       <= pend_nx;
            pend_err   <= pend_err_nx;
            pend_len   <= pend_len_nx;
            stat_vld_r <= emit;
            if (emit) begin
                stat_ok_r  <= ~|emit_err;
                stat_err_r <= emit_err;
                stat_len_r <= emit_len;
            end

            if (in_vld) begin
                if (in_sop) begin
                    last <= in_dat;
                    len  <= LEN_ONE;
                    err  <= {in_err, 3'b000};
                end else if (state == PKT) begin
                    last <= in_dat;
                    len  <= len_inc;
                    err  <= beat_err;
                end
            end

            // Counters trail the status pulse by one cycle; clear wins over counting.
            if (clr) begin
                pkt_cnt_r <= '0;
                err_cnt_r <= '0;
            end else if (stat_vld_r) begin
                if (!(&pkt_cnt_r))
                    pkt_cnt_r <= pkt_cnt_r + 1'b1;
                if (!stat_ok_r && !(&err_cnt_r))
                    err_cnt_r <= err_cnt_r + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qs_snk.sv
// Directed bench for qs_snk: table of beats with expected outputs one edge later,
// plus hand sequences for length saturation and reset mid-packet.
module tb_qs_snk;

    localparam int W = 32;
    localparam int N = 16;
    localparam int CNT_W = 16;
    localparam int LEN_W = $clog2(N + 2);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_vld = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_err = 1'b0;
    logic [W-1:0]     in_dat = '0;
    logic             clr = 1'b0;
    logic             stat_vld_r, stat_ok_r, busy_r;
    logic [3:0]       stat_err_r;
    logic [LEN_W-1:0] stat_len_r;
    logic [CNT_W-1:0] pkt_cnt_r, err_cnt_r;

    int checks = 0;
    int errors = 0;

    qs_snk #(.W(W), .N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop), .in_err(in_err), .in_dat(in_dat),
        .clr(clr),
        .stat_vld_r(stat_vld_r), .stat_ok_r(stat_ok_r), .stat_err_r(stat_err_r),
        .stat_len_r(stat_len_r), .busy_r(busy_r),
        .pkt_cnt_r(pkt_cnt_r), .err_cnt_r(err_cnt_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld, sop, eop, er;
        logic [31:0] dat;
        logic        clr;
        logic        e_vld, e_ok;
        logic [3:0]  e_err;
        logic [4:0]  e_len;
        logic        e_busy;
        logic [15:0] e_pkt, e_errc;
    } vec_t;

    vec_t vecs[23];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic e, input logic r,
                         input logic [31:0] d, input logic c);
        in_vld = v; in_sop = s; in_eop = e; in_err = r; in_dat = d; clr = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           vld sop eop er dat clr  e_vld ok err      len  busy pkt errc
        vecs[0]  = '{1, 1, 0, 0, 3,  0,   0, 0, 4'b0000, 0,  1, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 5,  0,   0, 0, 4'b0000, 0,  1, 0, 0};
        vecs[2]  = '{1, 0, 0, 0, 5,  0,   0, 0, 4'b0000, 0,  1, 0, 0};
        vecs[3]  = '{1, 0, 1, 0, 9,  0,   1, 1, 4'b0000, 4,  0, 0, 0};
        vecs[4]  = '{1, 1, 0, 0, 7,  0,   0, 0, 4'b0000, 0,  1, 1, 0};
        vecs[5]  = '{1, 0, 0, 0, 2,  0,   0, 0, 4'b0000, 0,  1, 1, 0};
        vecs[6]  = '{1, 0, 1, 0, 8,  0,   1, 0, 4'b0001, 3,  0, 1, 0};
        vecs[7]  = '{0, 0, 0, 0, 0,  0,   0, 0, 4'b0000, 0,  0, 2, 1};
        vecs[8]  = '{1, 1, 0, 0, 1,  0,   0, 0, 4'b0000, 0,  1, 2, 1};
        vecs[9]  = '{1, 0, 0, 0, 2,  0,   0, 0, 4'b0000, 0,  1, 2, 1};
        vecs[10] = '{1, 1, 0, 0, 4,  0,   1, 0, 4'b0010, 2,  1, 2, 1};
        vecs[11] = '{1, 0, 1, 0, 6,  0,   1, 1, 4'b0000, 2,  0, 3, 2};
        vecs[12] = '{0, 0, 0, 0, 0,  0,   0, 0, 4'b0000, 0,  0, 4, 2};
        vecs[13] = '{1, 0, 0, 0, 0,  0,   1, 0, 4'b0010, 0,  0, 4, 2};
        vecs[14] = '{1, 1, 1, 1, 5,  0,   1, 0, 4'b1000, 1,  0, 5, 3};
        vecs[15] = '{0, 0, 0, 0, 0,  0,   0, 0, 4'b0000, 0,  0, 6, 4};
        vecs[16] = '{1, 1, 0, 0, 10, 0,   0, 0, 4'b0000, 0,  1, 6, 4};
        vecs[17] = '{1, 1, 1, 0, 11, 0,   1, 0, 4'b0010, 1,  0, 6, 4};
        vecs[18] = '{0, 0, 0, 0, 0,  0,   1, 1, 4'b0000, 1,  0, 7, 5};
        vecs[19] = '{0, 0, 0, 0, 0,  0,   0, 0, 4'b0000, 0,  0, 8, 5};
        vecs[20] = '{1, 1, 1, 0, 1,  0,   1, 1, 4'b0000, 1,  0, 8, 5};
        vecs[21] = '{0, 0, 0, 0, 0,  1,   0, 0, 4'b0000, 0,  0, 0, 0};
        vecs[22] = '{0, 0, 0, 0, 0,  0,   0, 0, 4'b0000, 0,  0, 0, 0};

        #1;
        check("reset_async", {stat_vld_r, stat_ok_r, stat_err_r, stat_len_r, busy_r, pkt_cnt_r, err_cnt_r}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        step();
        check("reset_idle", {stat_vld_r, stat_ok_r, stat_err_r, stat_len_r, busy_r, pkt_cnt_r, err_cnt_r}, 64'd0);

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].vld, vecs[i].sop, vecs[i].eop, vecs[i].er, vecs[i].dat, vecs[i].clr);
            step();
            check($sformatf("v%0d_ctrl", i), {stat_vld_r, busy_r, pkt_cnt_r, err_cnt_r},
                  {vecs[i].e_vld, vecs[i].e_busy, vecs[i].e_pkt, vecs[i].e_errc});
            if (vecs[i].e_vld)
                check($sformatf("v%0d_stat", i), {stat_ok_r, stat_err_r, stat_len_r},
                      {vecs[i].e_ok, vecs[i].e_err, vecs[i].e_len});
        end

        // 18-beat ascending packet: LEN flagged, length saturates at N+1
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, i == 0, i == 17, 1'b0, 32'(100 + i), 1'b0);
            step();
            if (i < 17)
                check($sformatf("long_b%0d", i), {stat_vld_r, busy_r}, {1'b0, 1'b1});
        end
        check("long_stat", {stat_vld_r, stat_ok_r, stat_err_r, stat_len_r, busy_r},
              {1'b1, 1'b0, 4'b0100, 5'd17, 1'b0});
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step();
        check("long_cnt", {stat_vld_r, pkt_cnt_r, err_cnt_r}, {1'b0, 16'd1, 16'd1});

        // Reset in the middle of a packet discards it silently
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd4, 1'b0);
        step();
        check("mid_busy", busy_r, 64'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("mid_rst", {stat_vld_r, stat_ok_r, stat_err_r, stat_len_r, busy_r, pkt_cnt_r, err_cnt_r}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("post_rst%0d", i),
                  {stat_vld_r, stat_err_r, stat_len_r, busy_r, pkt_cnt_r, err_cnt_r}, 64'd0);
        end

        // Fresh packet after reset counts from zero
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd42, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        check("post_pkt", {stat_vld_r, stat_ok_r, stat_err_r, stat_len_r}, {1'b1, 1'b1, 4'b0000, 5'd1});
        step();
        check("post_cnt", {pkt_cnt_r, err_cnt_r}, {16'd1, 16'd0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
